// File: rtl/fetch_unit.sv
// Purpose: instruction-fetch stage. Holds the PC, fetches over req/gnt/rvalid, presents instr + decode fields.
// Latency: IDLE->REQ one cycle after reset; retire -> next instr_valid is 3 cycles minimum (REQ, WAIT, capture).
// Backpressure: imem_req and imem_addr stay asserted until imem_gnt; instr waits indefinitely for imem_rvalid.
//
// Ports:
//   clk, reset_n                        clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_gnt         fetch request handshake (one request outstanding at most)
//   imem_rvalid/imem_rdata              fetch response, only accepted while waiting for it
//   instr_valid/instr/pc/pcplus4        current instruction and its address
//   op/funct3/f7b5                      decode slices of the registered instruction
//   retire/pcsrc/pctarget               PC advance control, sampled only while an instruction is held
//   misalign                            sticky flag: a taken redirect had a non-word-aligned target
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pcplus4,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic            f7b5,
    input  logic            retire,
    input  logic            pcsrc,
    input  logic [XLEN-1:0] pctarget,
    output logic            misalign
);

    localparam logic [31:0]     NOP  = 32'h0000_0013;
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        VALID = 2'd3
    } state_t;

    state_t state;

    // The PC only changes on retire, so it doubles as the stable request address.
    assign imem_addr = pc;
    assign pcplus4   = pc + FOUR;

    // Decode fields come straight from the registered instruction, so they read as NOP fields after reset.
    assign op     = instr[6:0];
    assign funct3 = instr[14:12];
    assign f7b5   = instr[30];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= NOP;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            misalign    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    // rvalid is deliberately not looked at here: nothing is outstanding yet.
                    if (imem_gnt) begin
                        state    <= WAIT;
                        imem_req <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= VALID;
                    end
                end
                VALID: begin
                    if (retire) begin
                        // Redirect targets are forced to word alignment; a dropped low bit is flagged, not trapped.
                        if (pcsrc) begin
                            pc <= {pctarget[XLEN-1:2], 2'b00};
                            if (pctarget[1:0] != 2'b00) begin
                                misalign <= 1'b1;
                            end
                        end else begin
                            pc <= pc + FOUR;
                        end
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= REQ;
                    end
                end
                default: begin
                    state       <= IDLE;
                    instr_valid <= 1'b0;
                    imem_req    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            instr_valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
    logic [6:0]      op;
    logic [2:0]      funct3;
    logic            f7b5;
    logic            retire = 1'b0;
    logic            pcsrc = 1'b0;
    logic [XLEN-1:0] pctarget = '0;
    logic            misalign;

    fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .pc(pc), .pcplus4(pcplus4),
        .op(op), .funct3(funct3), .f7b5(f7b5),
        .retire(retire), .pcsrc(pcsrc), .pctarget(pctarget), .misalign(misalign)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: memory contents, architectural PC and sticky misalign flag.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] pc_m;
    bit          mis_m;

    // Memory responder knobs.
    int gnt_delay    = 0;
    int rvalid_delay = 1;
    bit spurious     = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    // Instruction memory: grants after gnt_delay request cycles, answers rvalid_delay cycles after gnt,
    // and optionally pulses garbage rvalid while a request is being held off.
    initial begin : responder
        bit          pend;
        int          gcnt;
        int          rcnt;
        logic [31:0] paddr;
        pend = 0; gcnt = 0; rcnt = 0; paddr = '0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_gnt    = 0;
            imem_rvalid = 0;
            if (!reset_n) begin
                pend = 0;
                gcnt = 0;
            end else if (pend) begin
                if (rcnt == 0) begin
                    imem_rvalid = 1;
                    imem_rdata  = mem_word(paddr);
                    pend        = 0;
                end else begin
                    rcnt--;
                end
            end else if (imem_req) begin
                if (gcnt >= gnt_delay) begin
                    imem_gnt = 1;
                    pend     = 1;
                    paddr    = imem_addr;
                    rcnt     = rvalid_delay - 1;
                    gcnt     = 0;
                end else begin
                    gcnt++;
                    if (spurious) begin
                        imem_rvalid = 1;
                        imem_rdata  = $urandom;
                    end
                end
            end
        end
    end

    task automatic wait_valid(output int n);
        n = 0;
        while (!instr_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!instr_valid) begin
            checks++; errors++;
            $display("FAIL wait_valid: instr_valid still low after %0d cycles, required high within 100", n);
            n = -1;
        end
    endtask

    // Drives one retire at the current (VALID) cycle and advances the model by the architectural rule.
    task automatic retire_once(input bit src, input logic [31:0] tgt);
        retire = 1; pcsrc = src; pctarget = tgt;
        @(negedge clk);
        retire = 0; pcsrc = 1'($urandom); pctarget = $urandom;
        if (src) begin
            pc_m = tgt - (tgt % 4);
            if (tgt % 4 != 0) mis_m = 1;
        end else begin
            pc_m = pc_m + 4;
        end
    endtask

    task automatic release_reset;
        @(posedge clk);
        #1 reset_n = 1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 0;
        pc_m = RESET_PC; mis_m = 0;
        mem[32'h0] = 32'h0050_0093;
        repeat (2) @(negedge clk);
        checks++;
        if ({imem_req, instr_valid, misalign} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl: req/valid/misalign=%b required 000", {imem_req, instr_valid, misalign});
        end
        checks++;
        if (pc !== RESET_PC || pcplus4 !== RESET_PC + 4) begin
            errors++;
            $display("FAIL reset_pc: pc=%h pcplus4=%h required %h %h", pc, pcplus4, RESET_PC, RESET_PC + 4);
        end
        checks++;
        if (instr !== NOP || op !== 7'h13 || funct3 !== 3'd0 || f7b5 !== 1'b0) begin
            errors++;
            $display("FAIL reset_instr: instr=%h op=%h f3=%0d f7b5=%b required NOP fields", instr, op, funct3, f7b5);
        end
    endtask

    task automatic test_first_fetch;
        release_reset();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_cycle: imem_req=%b required 0", imem_req);
        end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h required 1 %h", imem_req, imem_addr, RESET_PC);
        end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL first_wait: valid=%b req=%b required 0 0", instr_valid, imem_req);
        end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr !== 32'h0050_0093 || op !== 7'h13 || funct3 !== 3'd0 ||
            f7b5 !== 1'b0 || pc !== 32'h0 || pcplus4 !== 32'h4) begin
            errors++;
            $display("FAIL first_valid: valid=%b instr=%h op=%h f3=%0d pc=%h pc4=%h required 1 00500093 13 0 0 4",
                     instr_valid, instr, op, funct3, pc, pcplus4);
        end
    endtask

    task automatic test_sequential;
        int n;
        int lat;
        for (int i = 0; i < 4; i++) begin
            retire_once(0, $urandom);
            wait_valid(n);
        end
        checks++;
        if (pc !== 32'h10) begin
            errors++;
            $display("FAIL seq_pc10: pc=%h required 00000010", pc);
        end
        retire_once(0, $urandom);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h14 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL seq_req: req=%b addr=%h valid=%b required 1 00000014 0", imem_req, imem_addr, instr_valid);
        end
        // Count from the retire cycle itself up to the first cycle instr_valid is seen again.
        lat = 1;
        while (!instr_valid && lat < 50) begin
            lat++;
            @(negedge clk);
        end
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL seq_latency: retire-to-valid=%0d cycles required 3", lat);
        end
        checks++;
        if (pc !== pc_m || instr !== mem_word(pc_m) || pcplus4 !== pc_m + 4) begin
            errors++;
            $display("FAIL seq_valid: pc=%h instr=%h pc4=%h required %h %h %h", pc, instr, pcplus4,
                     pc_m, mem_word(pc_m), pc_m + 4);
        end
    endtask

    task automatic test_branch;
        int n;
        retire_once(1, 32'h100);
        checks++;
        if (imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL branch_addr: addr=%h required 00000100", imem_addr);
        end
        wait_valid(n);
        checks++;
        if (pc !== 32'h100 || misalign !== 1'b0 || instr !== mem_word(32'h100)) begin
            errors++;
            $display("FAIL branch_valid: pc=%h mis=%b instr=%h required 00000100 0 %h", pc, misalign, instr,
                     mem_word(32'h100));
        end
    endtask

    task automatic test_backpressure;
        int          n;
        logic [31:0] old_instr;
        logic [31:0] hold_addr;
        old_instr = instr;
        gnt_delay = 5; rvalid_delay = 3; spurious = 1;
        retire_once(0, $urandom);
        hold_addr = pc_m;
        // Five held-off request cycles plus the granting one; a retire held high here must be ignored.
        for (int i = 0; i < 6; i++) begin
            retire   = (i < 5);
            pcsrc    = 1;
            pctarget = 32'h40;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== hold_addr || instr !== old_instr || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: req=%b addr=%h instr=%h valid=%b required 1 %h %h 0",
                         i, imem_req, imem_addr, instr, instr_valid, hold_addr, old_instr);
            end
            @(negedge clk);
        end
        retire = 0;
        wait_valid(n);
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL bp_latency: gnt-to-valid wait=%0d cycles required 3", n);
        end
        checks++;
        if (pc !== pc_m || instr !== mem_word(pc_m)) begin
            errors++;
            $display("FAIL bp_valid: pc=%h instr=%h required %h %h", pc, instr, pc_m, mem_word(pc_m));
        end
        gnt_delay = 0; rvalid_delay = 1; spurious = 0;
    endtask

    task automatic test_misalign;
        int n;
        retire_once(1, 32'h203);
        wait_valid(n);
        checks++;
        if (pc !== 32'h200 || misalign !== 1'b1) begin
            errors++;
            $display("FAIL mis_set: pc=%h mis=%b required 00000200 1", pc, misalign);
        end
        for (int i = 0; i < 3; i++) begin
            retire_once(i == 1, 32'h300);
            wait_valid(n);
            checks++;
            if (misalign !== 1'b1 || pc !== pc_m) begin
                errors++;
                $display("FAIL mis_sticky[%0d]: mis=%b pc=%h required 1 %h", i, misalign, pc, pc_m);
            end
        end
    endtask

    task automatic test_random;
        int          n;
        bit          src;
        logic [31:0] tgt;
        logic [31:0] ei;
        for (int i = 0; i < 25; i++) begin
            gnt_delay    = $urandom_range(0, 3);
            rvalid_delay = $urandom_range(1, 4);
            spurious     = 1'($urandom);
            src          = 1'($urandom);
            tgt          = $urandom;
            if ($urandom_range(0, 3) != 0) tgt = tgt - (tgt % 4);
            retire_once(src, tgt);
            wait_valid(n);
            ei = mem_word(pc_m);
            checks++;
            if (pc !== pc_m || pcplus4 !== pc_m + 4 || instr !== ei || op !== ei[6:0] ||
                funct3 !== ei[14:12] || f7b5 !== ei[30] || misalign !== mis_m) begin
                errors++;
                $display("FAIL random[%0d]: pc=%h pc4=%h instr=%h mis=%b required %h %h %h %b",
                         i, pc, pcplus4, instr, misalign, pc_m, pc_m + 4, ei, mis_m);
            end
        end
        gnt_delay = 0; rvalid_delay = 1; spurious = 0;
    endtask

    task automatic test_wrap;
        int n;
        retire_once(1, 32'hFFFF_FFFC);
        wait_valid(n);
        checks++;
        if (pc !== 32'hFFFF_FFFC || pcplus4 !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc4: pc=%h pc4=%h required fffffffc 00000000", pc, pcplus4);
        end
        retire_once(0, $urandom);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr: req=%b addr=%h required 1 00000000", imem_req, imem_addr);
        end
        wait_valid(n);
        checks++;
        if (pc !== 32'h0 || instr !== mem_word(32'h0)) begin
            errors++;
            $display("FAIL wrap_valid: pc=%h instr=%h required 00000000 %h", pc, instr, mem_word(32'h0));
        end
    endtask

    task automatic test_reset_midop;
        int n;
        rvalid_delay = 5;
        retire_once(1, 32'h80);
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_wait: req=%b valid=%b required 0 0", imem_req, instr_valid);
        end
        #2 reset_n = 0;
        #1;
        checks++;
        if ({imem_req, instr_valid, misalign} !== 3'b000 || pc !== RESET_PC || instr !== NOP || op !== 7'h13) begin
            errors++;
            $display("FAIL mid_async: req/valid/mis=%b pc=%h instr=%h required 000 %h %h",
                     {imem_req, instr_valid, misalign}, pc, instr, RESET_PC, NOP);
        end
        pc_m = RESET_PC; mis_m = 0;
        repeat (2) @(negedge clk);
        rvalid_delay = 1;
        release_reset();
        wait_valid(n);
        checks++;
        if (pc !== RESET_PC || misalign !== 1'b0 || instr !== mem_word(RESET_PC)) begin
            errors++;
            $display("FAIL mid_refetch: pc=%h mis=%b instr=%h required %h 0 %h", pc, misalign, instr,
                     RESET_PC, mem_word(RESET_PC));
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        test_reset();
        test_first_fetch();
        test_sequential();
        test_branch();
        test_backpressure();
        test_misalign();
        test_random();
        test_wrap();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
